pwm_compare: RTL and testbench
==============================

// Module: pwm_compare
// PURPOSE
// - Downstream consumer of the free-running WIDTH-bit up counter: compares count_i to a duty value and drives a PWM output.
// - Duty is loaded through a valid/ready port into a shadow register. It takes effect only at counter wrap, so there are no glitched periods.
// - Emits a one-cycle period pulse per counter wrap. Sits between the counter and the pad/driver logic.
// PARAMETERS
// - WIDTH     4  counter width; period = 2**WIDTH clocks
// - DEADTIME  2  dead-time clocks between pwm_o/pwm_n_o edges (used only with PWM_COMPLEMENT_EN)
// PORTS
// - clk_i          in   1         single clock, rising edge
// - reset_i        in   1         asynchronous, active-high reset
// - count_i        in   WIDTH     counter value, same clock domain
// - cfg_valid_i    in   1         new duty offered
// - cfg_duty_i     in   WIDTH+1   duty in counts, 0..2**WIDTH
// - cfg_ready_o    out  1         shadow free; a duty may be accepted
// - pwm_o          out  1         PWM output (high side)
// - pwm_n_o        out  1         complementary output (constant 0 without macro)
// - period_o       out  1         one-cycle pulse, registered, at each wrap
// - duty_active_o  out  WIDTH+1   duty currently applied
// BEHAVIOUR
// - Reset (async assert, sync release): count_q=0, duty_active_o=0, shadow=0, cfg FSM=IDLE.
//   Outputs during reset: cfg_ready_o=1, pwm_o=0, pwm_n_o=0, period_o=0.
// - Wrap event: wrap = (count_i < count_q), where count_q is count_i registered.
//   Detects MAX->0. Also detects a counter restart to any lower value.
// - Duty clamp: cfg_duty_i > 2**WIDTH is clamped to 2**WIDTH when captured.
// - Config FSM:
//   - IDLE: cfg_ready_o=1. valid&ready -> shadow<=clamped duty, go to PEND.
//   - PEND: cfg_ready_o=0. On wrap: duty_active<=shadow, go to IDLE.
//   - Handshake accepted in the same cycle as a wrap: the value goes to shadow and is applied at the NEXT wrap, not this one.
//   - No handshake in PEND. Offered data is held by the source until ready.
// - Raw compare, registered, latency 1 clk:
//   - raw_q <= ({1'b0,count_i} < duty_eff).
//   - duty_eff is the shadow on a wrap cycle in PEND, otherwise duty_active.
//   - duty 0 -> always low. duty 2**WIDTH -> always high.
// - period_o <= wrap (1 clk latency). Exactly one pulse per wrap.
// - Reset mid-operation: a pending shadow is discarded. After release, duty_active=0 until a new load and a wrap.
// CONFIGURATION
// - Macro PWM_COMPLEMENT_EN, defined: dead-time generator inserted after raw_q.
//   - States OFF_BOTH, HI_ON, LO_ON, with a DEADTIME down-counter.
//   - On a raw_q edge: go to OFF_BOTH and load the timer. At 0, enter HI_ON if raw_q=1, else LO_ON.
//   - raw_q toggling during OFF_BOTH reloads the timer; the target follows raw_q.
//   - pwm_o = (state==HI_ON); pwm_n_o = (state==LO_ON). Never both high.
//   - DEADTIME=0: pwm_n_o = ~pwm_o, no added latency.
//   - Reset state is OFF_BOTH with timer 0 -> LO_ON on the first cycle after release.
// - Macro not defined: pwm_o = raw_q, pwm_n_o = 0. No dead-time logic synthesised.
// STRUCTURE
// - pwm_pkg holds:
//   - typedef enum cfg_state_e {CFG_IDLE, CFG_PEND}
//   - typedef enum dt_state_e {DT_OFF_BOTH, DT_HI_ON, DT_LO_ON}
//   - function clamp_duty()
// - Sub-module pwm_deadtime (DEADTIME param; raw_i -> hi_o, lo_o), instantiated only under PWM_COMPLEMENT_EN.
// - Top level holds the wrap detect, cfg FSM, shadow/active registers and compare.
// TESTING  (WIDTH=4 with upstream counter; DEADTIME=2)
// - Counter runs with reset_i=1 -> pwm_o=0, pwm_n_o=0, period_o=0, cfg_ready_o=1, duty_active_o=0.
// - Duty 4 offered at count 7 -> cfg_ready_o=0 next clk; pwm_o stays 0.
//   At wrap 15->0: period_o one pulse, duty_active_o=4.
//   pwm_o high while count_i=0..3 (1 clk lag), 12 clks low; ready back to 1.
// - Duty 0 -> pwm_o never high. Duty 16 -> pwm_o constant 1. Duty 20 -> duty_active_o=16.
// - Duty offered on the wrap cycle -> not applied this period; applied at the following wrap, 16 clks later.
// - reset_i pulsed while in PEND (shadow=9) -> after release duty_active_o=0, cfg_ready_o=1, 9 never applied.
// - With PWM_COMPLEMENT_EN and duty 8 -> pwm_o&pwm_n_o never 1.
//   Exactly 2 clks both low around every edge; pwm_o high for 6 clks per period.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: state encodings, default parameters and the duty clamp shared by
// the PWM compare block and its optional dead-time generator.
package pwm_pkg;

  localparam int PWM_WIDTH_DEFAULT    = 4;
  localparam int PWM_DEADTIME_DEFAULT = 2;

  typedef enum logic [0:0] {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } cfg_state_e;

  typedef enum logic [1:0] {
    DT_OFF_BOTH = 2'd0,
    DT_HI_ON    = 2'd1,
    DT_LO_ON    = 2'd2
  } dt_state_e;

  // Duties above one full period would only mean "always high", so saturate there.
  function automatic logic [31:0] clamp_duty(input logic [31:0] duty, input int width);
    logic [31:0] full;
    full = 32'd1 << width;
    return (duty > full) ? full : duty;
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: splits the raw compare into non-overlapping high/low drives
// separated by DEADTIME clocks of both-off.
//
// state       | meaning
// DT_OFF_BOTH | both drives off, timer counting down the dead time
// DT_HI_ON    | high-side drive on
// DT_LO_ON    | low-side drive on
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DEADTIME = PWM_DEADTIME_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic hi_o,
  output logic lo_o
);

  if (DEADTIME == 0) begin : g_direct
    // Without dead time the drives follow raw directly; run_q keeps both off in reset.
    logic run_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        run_q <= 1'b0;
      end else begin
        run_q <= 1'b1;
      end
    end

    assign hi_o = raw_i & run_q;
    assign lo_o = ~raw_i & run_q;
  end else begin : g_timer
    localparam int TW = $clog2(DEADTIME + 1);
    localparam logic [TW-1:0] RELOAD = TW'(DEADTIME - 1);

    dt_state_e     state_q;
    logic [TW-1:0] timer_q;
    logic          raw_prev_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        state_q    <= DT_OFF_BOTH;
        timer_q    <= '0;
        raw_prev_q <= 1'b0;
      end else begin
        raw_prev_q <= raw_i;
        if (raw_i != raw_prev_q) begin
          // Any raw edge, including one inside the dead band, restarts the band.
          state_q <= DT_OFF_BOTH;
          timer_q <= RELOAD;
        end else if (state_q == DT_OFF_BOTH) begin
          if (timer_q == '0) begin
            state_q <= raw_i ? DT_HI_ON : DT_LO_ON;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
      end
    end

    assign hi_o = (state_q == DT_HI_ON);
    assign lo_o = (state_q == DT_LO_ON);
  end

endmodule

// File: rtl/pwm_compare.sv
// pwm_compare: PWM from an external free-running counter with wrap-synchronised
// duty update. Define PWM_COMPLEMENT_EN to add the complementary dead-time output.
//
// state    | meaning
// CFG_IDLE | shadow free, ready to accept a duty
// CFG_PEND | shadow holds a duty waiting for the next wrap
module pwm_compare
  import pwm_pkg::*;
#(
  parameter int WIDTH    = PWM_WIDTH_DEFAULT,
  parameter int DEADTIME = PWM_DEADTIME_DEFAULT
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] count_i,
  input  logic             cfg_valid_i,
  input  logic [WIDTH:0]   cfg_duty_i,
  output logic             cfg_ready_o,
  output logic             pwm_o,
  output logic             pwm_n_o,
  output logic             period_o,
  output logic [WIDTH:0]   duty_active_o
);

  localparam int DW = WIDTH + 1;

  logic [WIDTH-1:0] count_q;
  logic             wrap;
  cfg_state_e       cfg_state_q;
  logic             ready_q;
  logic [DW-1:0]    shadow_q;
  logic [DW-1:0]    duty_active_q;
  logic [DW-1:0]    duty_clamped;
  logic [DW-1:0]    duty_eff;
  logic             raw_q;
  logic             period_q;

  // A drop in count is a wrap, whether from MAX or from a counter restart.
  assign wrap         = (count_i < count_q);
  assign duty_clamped = DW'(clamp_duty(32'(cfg_duty_i), WIDTH));
  assign duty_eff     = (cfg_state_q == CFG_PEND && wrap) ? shadow_q : duty_active_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cfg_state_q   <= CFG_IDLE;
      ready_q       <= 1'b1;
      shadow_q      <= '0;
      duty_active_q <= '0;
    end else begin
      case (cfg_state_q)
        CFG_IDLE: begin
          if (cfg_valid_i) begin
            shadow_q    <= duty_clamped;
            cfg_state_q <= CFG_PEND;
            ready_q     <= 1'b0;
          end
        end
        CFG_PEND: begin
          if (wrap) begin
            duty_active_q <= shadow_q;
            cfg_state_q   <= CFG_IDLE;
            ready_q       <= 1'b1;
          end
        end
        default: begin
          cfg_state_q <= CFG_IDLE;
          ready_q     <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q  <= '0;
      raw_q    <= 1'b0;
      period_q <= 1'b0;
    end else begin
      count_q  <= count_i;
      raw_q    <= ({1'b0, count_i} < duty_eff);
      period_q <= wrap;
    end
  end

  assign cfg_ready_o   = ready_q;
  assign period_o      = period_q;
  assign duty_active_o = duty_active_q;

`ifdef PWM_COMPLEMENT_EN
  pwm_deadtime #(
    .DEADTIME (DEADTIME)
  ) u_deadtime (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .raw_i   (raw_q),
    .hi_o    (pwm_o),
    .lo_o    (pwm_n_o)
  );
`else
  assign pwm_o   = raw_q;
  assign pwm_n_o = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_compare.sv
// tb_pwm_compare: directed vectors for pwm_compare with a 4-bit upstream counter
// driven by the bench.
module tb_pwm_compare;

  localparam int WIDTH    = 4;
  localparam int DEADTIME = 2;
  localparam int PERIOD   = 16;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [3:0] count_i;
  logic       cfg_valid_i;
  logic [4:0] cfg_duty_i;
  logic       cfg_ready_o;
  logic       pwm_o;
  logic       pwm_n_o;
  logic       period_o;
  logic [4:0] duty_active_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0] duty;
    logic [4:0] exp_active;
    int         exp_high;
  } vec_t;

  vec_t vecs[7];

  always #5 clk_i = ~clk_i;

  pwm_compare #(
    .WIDTH    (WIDTH),
    .DEADTIME (DEADTIME)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .count_i       (count_i),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_duty_i    (cfg_duty_i),
    .cfg_ready_o   (cfg_ready_o),
    .pwm_o         (pwm_o),
    .pwm_n_o       (pwm_n_o),
    .period_o      (period_o),
    .duty_active_o (duty_active_o)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One clock: the edge consumes the current count, then the counter advances.
  task automatic tick();
    @(posedge clk_i);
    #1;
    count_i = count_i + 4'd1;
  endtask

  task automatic wait_count(input logic [3:0] v);
    int guard = 0;
    while (count_i != v && guard < 40) begin
      tick();
      guard++;
    end
    check("wait_count", int'(count_i), int'(v));
  endtask

  task automatic wait_period(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!period_o && n < 40);
    check("wait_period", int'(period_o), 1);
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!cfg_ready_o && guard < 40) begin
      tick();
      guard++;
    end
    check("wait_ready", int'(cfg_ready_o), 1);
  endtask

  task automatic offer(input logic [4:0] d);
    cfg_valid_i = 1'b1;
    cfg_duty_i  = d;
    tick();
    cfg_valid_i = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    int hi;
    int pulses;
    int exp_hi;
    int both;
    wait_ready();
    wait_count(4'd5);
    offer(v.duty);
    check($sformatf("vec%0d_ready_low", idx), int'(cfg_ready_o), 0);
    wait_period(n);
    check($sformatf("vec%0d_active", idx), int'(duty_active_o), int'(v.exp_active));
`ifdef PWM_COMPLEMENT_EN
    repeat (PERIOD) tick();
    exp_hi = (v.exp_high >= PERIOD) ? PERIOD : ((v.exp_high > DEADTIME) ? v.exp_high - DEADTIME : 0);
`else
    exp_hi = v.exp_high;
`endif
    hi = 0;
    pulses = 0;
    both = 0;
    for (int k = 0; k < PERIOD; k++) begin
      if (k > 0) tick();
      hi += int'(pwm_o);
      pulses += int'(period_o);
      both += int'(pwm_o & pwm_n_o);
    end
    check($sformatf("vec%0d_high_clks", idx), hi, exp_hi);
    check($sformatf("vec%0d_pulses", idx), pulses, 1);
    check($sformatf("vec%0d_overlap", idx), both, 0);
  endtask

  initial begin
    int n;
    int bad;
    int bad_pulse;
    int both_hi;
    int both_lo;
    int hi;

    vecs[0] = '{duty: 5'd0,  exp_active: 5'd0,  exp_high: 0};
    vecs[1] = '{duty: 5'd16, exp_active: 5'd16, exp_high: 16};
    vecs[2] = '{duty: 5'd20, exp_active: 5'd16, exp_high: 16};
    vecs[3] = '{duty: 5'd1,  exp_active: 5'd1,  exp_high: 1};
    vecs[4] = '{duty: 5'd15, exp_active: 5'd15, exp_high: 15};
    vecs[5] = '{duty: 5'd8,  exp_active: 5'd8,  exp_high: 8};
    vecs[6] = '{duty: 5'd31, exp_active: 5'd16, exp_high: 16};

    reset_i     = 1'b1;
    count_i     = 4'd0;
    cfg_valid_i = 1'b0;
    cfg_duty_i  = 5'd0;

    // Counter keeps running while reset is held.
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_pwm", int'(pwm_o), 0);
      check("rst_pwm_n", int'(pwm_n_o), 0);
      check("rst_period", int'(period_o), 0);
      check("rst_ready", int'(cfg_ready_o), 1);
      check("rst_active", int'(duty_active_o), 0);
    end
    reset_i = 1'b0;

    // Duty 4 offered at count 7.
    wait_count(4'd7);
    offer(5'd4);
    check("d4_ready_low", int'(cfg_ready_o), 0);
    check("d4_pwm_before", int'(pwm_o), 0);
    bad = 0;
    n = 0;
    do begin
      tick();
      n++;
      if (!period_o && pwm_o) bad++;
    end while (!period_o && n < 40);
    check("d4_wrap_latency", n, 9);
    check("d4_pwm_low_until_wrap", bad, 0);
    check("d4_active", int'(duty_active_o), 4);
    check("d4_ready_back", int'(cfg_ready_o), 1);
    for (int k = 0; k < PERIOD; k++) begin
      if (k > 0) tick();
`ifndef PWM_COMPLEMENT_EN
      check($sformatf("d4_pwm_k%0d", k), int'(pwm_o), (k < 4) ? 1 : 0);
`endif
      check($sformatf("d4_period_k%0d", k), int'(period_o), (k == 0) ? 1 : 0);
    end
    tick();
    check("d4_next_period", int'(period_o), 1);

    for (int i = 0; i < 7; i++) begin
      run_vec(i, vecs[i]);
    end

    // Handshake on the wrap cycle: applied only at the following wrap.
    wait_ready();
    wait_count(4'd0);
    offer(5'd10);
    check("wrapcyc_period", int'(period_o), 1);
    check("wrapcyc_ready_low", int'(cfg_ready_o), 0);
    check("wrapcyc_active_old", int'(duty_active_o), 16);
    bad = 0;
    bad_pulse = 0;
    for (int k = 1; k < PERIOD; k++) begin
      tick();
      if (duty_active_o != 5'd16) bad++;
      if (period_o) bad_pulse++;
    end
    check("wrapcyc_active_held", bad, 0);
    check("wrapcyc_no_pulse", bad_pulse, 0);
    tick();
    check("wrapcyc_period_next", int'(period_o), 1);
    check("wrapcyc_active_new", int'(duty_active_o), 10);

    // Counter restart to a lower value counts as a wrap.
    wait_ready();
    wait_count(4'd5);
    offer(5'd3);
    tick();
    tick();
    tick();
    check("restart_no_pulse", int'(period_o), 0);
    count_i = 4'd2;
    tick();
    check("restart_period", int'(period_o), 1);
    check("restart_active", int'(duty_active_o), 3);
    wait_period(n);
    check("restart_next_wrap", n, 14);

    // Reset while a duty is pending discards the shadow.
    wait_ready();
    wait_count(4'd5);
    offer(5'd9);
    check("rstpend_ready_low", int'(cfg_ready_o), 0);
    reset_i = 1'b1;
    tick();
    tick();
    check("rstpend_active_in_rst", int'(duty_active_o), 0);
    reset_i = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (duty_active_o != 5'd0 || !cfg_ready_o || pwm_o) bad++;
    end
    check("rstpend_shadow_dropped", bad, 0);
    check("rstpend_ready", int'(cfg_ready_o), 1);

`ifdef PWM_COMPLEMENT_EN
    // Dead-time shape with duty 8 over two full periods.
    wait_ready();
    wait_count(4'd5);
    offer(5'd8);
    wait_period(n);
    repeat (PERIOD) tick();
    both_hi = 0;
    both_lo = 0;
    hi = 0;
    for (int k = 0; k < 2 * PERIOD; k++) begin
      tick();
      both_hi += int'(pwm_o & pwm_n_o);
      both_lo += int'(!pwm_o && !pwm_n_o);
      hi += int'(pwm_o);
    end
    check("dt_overlap", both_hi, 0);
    check("dt_both_low", both_lo, 8);
    check("dt_high", hi, 12);
`else
    bad = 0;
    for (int k = 0; k < PERIOD; k++) begin
      tick();
      if (pwm_n_o) bad++;
    end
    check("pwm_n_zero", bad, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d of %0d checks failed", n_fail, n_tests);
    $fatal(1, "watchdog");
  end

endmodule
